// File: rtl/pipe_hold_ctrl_if.sv
// Handshake bundle between the pipeline sequencing controller and the blocks
// around it: execute, interrupt controller, bus arbiter, debug port, PC/IF/ID.
//   slave  : controller side (requests in, jump/hold/halt out)
//   master : requester / stage side (drives requests, observes controls)
// Signals:
//   ex_jump_req_i/ex_jump_addr_i  execute redirect
//   ex_hold_req_i                 multi-cycle execute op busy
//   int_assert_i/int_addr_i       trap/mret redirect (1-cycle pulse)
//   rib_hold_req_i                bus arbiter owns the instruction port
//   jtag_halt_req_i/jtag_halted_o debug halt handshake
//   jump_flag_o/jump_addr_o       PC redirect
//   hold_flag_o                   0 none, 1 Pc, 2 If, 3 Id
//   hold_cycles_o                 stall cycle count (0 when stats not built)
interface pipe_hold_ctrl_if #(parameter int ADDR_W = 32);
  logic              ex_jump_req_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              ex_hold_req_i;
  logic              int_assert_i;
  logic [ADDR_W-1:0] int_addr_i;
  logic              rib_hold_req_i;
  logic              jtag_halt_req_i;
  logic              jtag_halted_o;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [2:0]        hold_flag_o;
  logic [15:0]       hold_cycles_o;

  modport slave (
    input  ex_jump_req_i, ex_jump_addr_i, ex_hold_req_i, int_assert_i,
           int_addr_i, rib_hold_req_i, jtag_halt_req_i,
    output jtag_halted_o, jump_flag_o, jump_addr_o, hold_flag_o, hold_cycles_o
  );

  modport master (
    output ex_jump_req_i, ex_jump_addr_i, ex_hold_req_i, int_assert_i,
           int_addr_i, rib_hold_req_i, jtag_halt_req_i,
    input  jtag_halted_o, jump_flag_o, jump_addr_o, hold_flag_o, hold_cycles_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline sequencing controller for the RV32I core.
// Arbitrates execute/interrupt redirects, merges stall requests into one hold
// level for PC/IF/ID, and runs the debug halt/resume handshake. Interrupts
// that arrive while halted are parked and replayed on the first RUN cycle.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  pipe_hold_ctrl_if.slave (requests in, jump/hold/halt controls out)
// Parameters:
//   ADDR_W        instruction address width
//   DRAIN_CYCLES  cycles fetch is frozen before halt is acknowledged (>=1)
// Build option:
//   HOLD_STATS_EN  when defined, hold_cycles_o is a saturating 16-bit count
//                  of cycles with hold_flag_o != 0; otherwise tied to 0.
module pipe_hold_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst,
  pipe_hold_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, RESUME} state_t;

  localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [2:0]      HOLD_NONE = 3'd0;
  localparam logic [2:0]      HOLD_PC   = 3'd1;
  localparam logic [2:0]      HOLD_ID   = 3'd3;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              halted_q;

  logic              jump_flag;
  logic [ADDR_W-1:0] jump_addr;
  logic [2:0]        fsm_hold;
  logic [2:0]        hold;

  // Redirect arbitration. Nothing is forwarded while halted/resuming: execute
  // is frozen and interrupts are parked in the pending register instead.
  always_comb begin
    jump_flag = 1'b0;
    jump_addr = '0;
    if (!rst && (state_q == RUN || state_q == DRAIN)) begin
      if (state_q == RUN && pend_vld_q) begin
        jump_flag = 1'b1;
        jump_addr = pend_addr_q;
      end else if (bus.int_assert_i) begin
        jump_flag = 1'b1;
        jump_addr = bus.int_addr_i;
      end else if (bus.ex_jump_req_i) begin
        jump_flag = 1'b1;
        jump_addr = bus.ex_jump_addr_i;
      end
    end
  end

  // Hold level is the max of all contributors; a jump still wins at the PC.
  always_comb begin
    fsm_hold = HOLD_NONE;
    case (state_q)
      DRAIN:          fsm_hold = HOLD_PC;
      HALTED, RESUME: fsm_hold = HOLD_ID;
      default:        fsm_hold = HOLD_NONE;
    endcase
    hold = fsm_hold;
    if (bus.rib_hold_req_i && hold < HOLD_PC) hold = HOLD_PC;
    if (jump_flag || bus.ex_hold_req_i)       hold = HOLD_ID;
    if (rst)                                   hold = HOLD_NONE;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      RUN: begin
        // The replay goes out this cycle unconditionally (top priority).
        pend_vld_d = 1'b0;
        if (bus.jtag_halt_req_i) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      DRAIN: begin
        if (!bus.jtag_halt_req_i)  state_d = RUN;
        else if (jump_flag)        cnt_d   = CNT_LOAD;  // refill after flush
        else if (cnt_q == '0)      state_d = HALTED;
        else                       cnt_d   = cnt_q - 1'b1;
      end
      HALTED: begin
        if (!bus.jtag_halt_req_i) state_d = RESUME;
      end
      default: state_d = RUN;  // RESUME lasts exactly one cycle
    endcase
    if ((state_q == HALTED || state_q == RESUME) && bus.int_assert_i) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = bus.int_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      halted_q    <= (state_d == HALTED);
    end
  end

  assign bus.jump_flag_o   = jump_flag;
  assign bus.jump_addr_o   = jump_addr;
  assign bus.hold_flag_o   = hold;
  assign bus.jtag_halted_o = halted_q;

`ifdef HOLD_STATS_EN
  logic [15:0] hold_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                                     hold_cnt_q <= '0;
    else if (hold != HOLD_NONE && hold_cnt_q != 16'hFFFF) hold_cnt_q <= hold_cnt_q + 16'd1;
  end
  assign bus.hold_cycles_o = hold_cnt_q;
`else
  assign bus.hold_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl (ADDR_W=32, DRAIN_CYCLES=3).
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, well away from the next edge.
module tb_pipe_hold_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl_if #(.ADDR_W(32)) bus ();

  pipe_hold_ctrl #(.ADDR_W(32), .DRAIN_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Execute must be frozen while the core reports halted.
  always @(negedge clk) begin
    if (!rst && bus.jtag_halted_o && bus.ex_jump_req_i) begin
      bad++;
      $error("FAIL illegal_ex_jump_while_halted: got 1 want 0");
    end
  end

  initial begin
    bus.ex_jump_req_i   = 1'b0;
    bus.ex_jump_addr_i  = '0;
    bus.ex_hold_req_i   = 1'b0;
    bus.int_assert_i    = 1'b0;
    bus.int_addr_i      = '0;
    bus.rib_hold_req_i  = 1'b0;
    bus.jtag_halt_req_i = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_jump", 32'(bus.jump_flag_o), 32'd0);
    chk("rst_hold", 32'(bus.hold_flag_o), 32'd0);
    chk("rst_halted", 32'(bus.jtag_halted_o), 32'd0);
    chk("rst_stats", 32'(bus.hold_cycles_o), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_hold", 32'(bus.hold_flag_o), 32'd0);
      chk("idle_jump", 32'(bus.jump_flag_o), 32'd0);
      chk("idle_halted", 32'(bus.jtag_halted_o), 32'd0);
    end

    // Interrupt beats ex jump in the same cycle
    bus.ex_jump_req_i = 1'b1; bus.ex_jump_addr_i = 32'h100;
    bus.int_assert_i  = 1'b1; bus.int_addr_i     = 32'h80;
    #1;
    chk("arb_jump", 32'(bus.jump_flag_o), 32'd1);
    chk("arb_addr", bus.jump_addr_o, 32'h80);
    chk("arb_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    bus.int_assert_i = 1'b0;
    #1;
    chk("ex_only_addr", bus.jump_addr_o, 32'h100);
    chk("ex_only_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    bus.ex_jump_req_i = 1'b0;
    bus.rib_hold_req_i = 1'b1;
    #1;
    chk("rib_hold", 32'(bus.hold_flag_o), 32'd1);
    chk("rib_nojump", 32'(bus.jump_flag_o), 32'd0);
    chk("rib_addr0", bus.jump_addr_o, 32'h0);
    bus.ex_hold_req_i = 1'b1;
    #1;
    chk("rib_ex_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    bus.ex_hold_req_i = 1'b0; bus.rib_hold_req_i = 1'b0;

    // Plain halt / resume
    bus.jtag_halt_req_i = 1'b1;
    #1;
    chk("halt_req_run_hold", 32'(bus.hold_flag_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_hold", 32'(bus.hold_flag_o), 32'd1);
      chk("drain_halted", 32'(bus.jtag_halted_o), 32'd0);
    end
    tick();
    chk("halted_ack", 32'(bus.jtag_halted_o), 32'd1);
    chk("halted_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    chk("halted_stay", 32'(bus.jtag_halted_o), 32'd1);
    bus.jtag_halt_req_i = 1'b0;
    tick();
    chk("resume_halted", 32'(bus.jtag_halted_o), 32'd0);
    chk("resume_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    chk("run_after_resume_hold", 32'(bus.hold_flag_o), 32'd0);
    chk("run_after_resume_jump", 32'(bus.jump_flag_o), 32'd0);

    // Ex jump on 2nd DRAIN cycle restarts the drain count
    bus.jtag_halt_req_i = 1'b1;
    tick();
    chk("d1_hold", 32'(bus.hold_flag_o), 32'd1);
    tick();
    bus.ex_jump_req_i = 1'b1; bus.ex_jump_addr_i = 32'h200;
    #1;
    chk("drain_jump", 32'(bus.jump_flag_o), 32'd1);
    chk("drain_jump_addr", bus.jump_addr_o, 32'h200);
    chk("drain_jump_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    bus.ex_jump_req_i = 1'b0;
    #1;
    chk("refill1_hold", 32'(bus.hold_flag_o), 32'd1);
    chk("refill1_halted", 32'(bus.jtag_halted_o), 32'd0);
    tick();
    chk("refill2_halted", 32'(bus.jtag_halted_o), 32'd0);
    tick();
    chk("refill3_halted", 32'(bus.jtag_halted_o), 32'd0);
    tick();
    chk("refill_done_halted", 32'(bus.jtag_halted_o), 32'd1);

    // Interrupts while HALTED are parked; last one wins; replayed once
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h30;
    #1;
    chk("halted_int_nojump", 32'(bus.jump_flag_o), 32'd0);
    tick();
    bus.int_addr_i = 32'h40;
    #1;
    chk("halted_int2_nojump", 32'(bus.jump_flag_o), 32'd0);
    chk("halted_int2_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    bus.int_assert_i = 1'b0;
    bus.jtag_halt_req_i = 1'b0;
    #1;
    chk("halted_release_nojump", 32'(bus.jump_flag_o), 32'd0);
    tick();
    chk("resume_nojump", 32'(bus.jump_flag_o), 32'd0);
    tick();
    chk("replay_jump", 32'(bus.jump_flag_o), 32'd1);
    chk("replay_addr", bus.jump_addr_o, 32'h40);
    chk("replay_hold", 32'(bus.hold_flag_o), 32'd3);
    tick();
    chk("replay_once", 32'(bus.jump_flag_o), 32'd0);
    chk("replay_once_hold", 32'(bus.hold_flag_o), 32'd0);

    // Interrupt passes through in DRAIN; dropping halt aborts without ack
    bus.jtag_halt_req_i = 1'b1;
    tick();
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h80;
    #1;
    chk("drain_int_jump", 32'(bus.jump_flag_o), 32'd1);
    chk("drain_int_addr", bus.jump_addr_o, 32'h80);
    tick();
    bus.int_assert_i = 1'b0;
    bus.jtag_halt_req_i = 1'b0;
    #1;
    chk("abort_drain_hold", 32'(bus.hold_flag_o), 32'd1);
    tick();
    chk("abort_run_hold", 32'(bus.hold_flag_o), 32'd0);
    chk("abort_no_ack", 32'(bus.jtag_halted_o), 32'd0);
    tick();
    chk("abort_no_ack2", 32'(bus.jtag_halted_o), 32'd0);

    // Reset while HALTED drops the pending interrupt
    bus.jtag_halt_req_i = 1'b1;
    repeat (4) tick();
    chk("pre_rst_halted", 32'(bus.jtag_halted_o), 32'd1);
    bus.int_assert_i = 1'b1; bus.int_addr_i = 32'h50;
    tick();
    bus.int_assert_i = 1'b0;
    bus.jtag_halt_req_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_halted", 32'(bus.jtag_halted_o), 32'd0);
    chk("mid_rst_hold", 32'(bus.hold_flag_o), 32'd0);
    chk("mid_rst_nojump", 32'(bus.jump_flag_o), 32'd0);
    tick();
    chk("mid_rst_no_replay", 32'(bus.jump_flag_o), 32'd0);
    chk("stats_after_rst", 32'(bus.hold_cycles_o), 32'd0);

    // Stall statistics
    bus.rib_hold_req_i = 1'b1;
    tick();
    tick();
    bus.ex_hold_req_i = 1'b1;
    tick();
    tick();
    bus.ex_hold_req_i = 1'b0;
    tick();
    bus.rib_hold_req_i = 1'b0;
`ifdef HOLD_STATS_EN
    chk("stats_5", 32'(bus.hold_cycles_o), 32'd5);
    bus.ex_hold_req_i = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    bus.ex_hold_req_i = 1'b0;
    chk("stats_sat", 32'(bus.hold_cycles_o), 32'hFFFF);
    tick();
    chk("stats_sat_hold", 32'(bus.hold_cycles_o), 32'hFFFF);
`else
    chk("stats_off", 32'(bus.hold_cycles_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
